if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage between the PC register and the IF/ID pipeline register.
- Consumes the current fetch PC and looks it up in a direct-mapped, one-word-per-line instruction cache.
- On a miss it runs a request/valid transaction to the memory controller.
- Drives if_stall back to the PC register, and registers pc/instruction/valid toward ID.

Parameters:
- ICACHE_IDX_W, 7, index width; cache holds 2^ICACHE_IDX_W words (default 128).
- ADDR_W, 32, address/instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc_i  in  ADDR_W  current fetch PC; word-aligned, pc[1:0] ignored.
- branch_interception  in  1  flush from EX; highest priority.
- id_stall  in  1  downstream stall; ID register must hold.
- if_stall  out  1  combinational; PC register must hold pc when 1.
- mem_req_o  out  1  fetch request to memory controller (registered).
- mem_addr_o  out  ADDR_W  word address of request (registered, pc[1:0]=0).
- mem_valid_i  in  1  one-cycle pulse: mem_inst_i valid for the outstanding request.
- mem_inst_i  in  ADDR_W  fetched instruction word.
- id_pc_o  out  ADDR_W  registered PC of the instruction handed to ID.
- id_inst_o  out  ADDR_W  registered instruction.
- id_valid_o  out  1  registered; id_inst_o is a real instruction.

Behaviour:
- Reset (async, rst_n=0): all cache valid bits 0; state IDLE; mem_req_o 0; mem_addr_o 0; id_pc_o 0; id_inst_o 0; id_valid_o 0. Reset mid-transaction abandons it silently.
- Cache addressing:
  - idx = pc[ICACHE_IDX_W+1:2]; tag = pc[ADDR_W-1:ICACHE_IDX_W+2].
  - hit = valid[idx] & tag match, evaluated combinationally on if_pc_i.
- FSM states: IDLE, WAIT (request outstanding for current pc), DRAIN (request outstanding but flushed).
- Protocol: mem_req_o and mem_addr_o stay constant from assertion until the cycle mem_valid_i=1. mem_req_o drops the next cycle. At most one request is outstanding.
- IDLE:
  - hit & !id_stall & !branch_interception: id_pc_o<=pc, id_inst_o<=line, id_valid_o<=1. Hit latency is 1 cycle (one instruction per cycle sustained).
  - miss & !branch_interception: mem_req_o<=1, mem_addr_o<={pc[31:2],2'b00}, go WAIT. Allowed even while id_stall=1.
  - miss & branch_interception: stay IDLE, no request.
- WAIT:
  - mem_valid_i: write the line (valid<=1, tag, data) and mem_req_o<=0, then:
    - if !id_stall & !branch_interception: id_* <= {mem_addr_o, mem_inst_i, 1}; go IDLE.
    - if id_stall: fill only; go IDLE; the next cycle hits.
  - branch_interception without mem_valid_i: go DRAIN and keep the request held.
- DRAIN:
  - Wait for mem_valid_i, fill the cache with the returned data (still correct for mem_addr_o), produce no output, go IDLE.
  - Further flushes in DRAIN are ignored (already discarding).
- if_stall = id_stall | (IDLE & !hit) | (WAIT & !mem_valid_i) | DRAIN.
- id_valid_o:
  - branch_interception forces id_valid_o<=0 in any state, overriding all other updates.
  - Otherwise id_stall holds all id_* registers unchanged.
  - Otherwise, no instruction delivered this cycle forces id_valid_o<=0 (bubble).
- Simultaneous events: flush + mem_valid_i in WAIT means fill, no output, go IDLE. Flush + hit means no output.
- No self-modifying-code coherence; the cache is never invalidated except by reset.

Decomposition:
- Shared defines (alongside InstAddrBus/InstBus): FSM state encodings, ICACHE_IDX_W default, NOP/zero instruction constant.
- One sub-module, icache_dm: storage plus valid/tag arrays. Combinational read port (hit, data) and one synchronous write port (we, idx, tag, data), async clear of valid bits.
- Request FSM and IF/ID output register stay in if_fetch.

Test Plan:
- Cold miss: reset, pc=0x0000_0000, memory returns 0x0000_0013 after 3 cycles → mem_req_o=1, addr 0x0; if_stall=1 until the valid cycle; next edge id_pc_o=0x0, id_inst_o=0x13, id_valid_o=1.
- Warm hits: pcs 0x0,0x4,0x8 preloaded, then replayed → one id_valid_o per cycle, if_stall=0, mem_req_o never asserted.
- Flush during miss: WAIT on pc=0x100, branch_interception pulse, pc→0x200, data arrives 2 cycles later → no ID output for 0x100. Line 0x100 is valid afterward. A new request for 0x200 is issued only after the DRAIN fill.
- Stall on fill: WAIT on 0x40, id_stall=1 in the mem_valid_i cycle → id_* unchanged, if_stall=1. After id_stall drops, 0x40 hits and is delivered with no memory request.
- Conflict eviction: fetch 0x0 then 0x200 (same idx, ICACHE_IDX_W=7), then 0x0 → third access misses and re-requests 0x0.
- Async reset mid-WAIT: rst_n low between edges → mem_req_o=0, id_valid_o=0 immediately. After release, previously cached pc misses.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int INST_ADDR_BUS    = 32;
  localparam int INST_BUS         = 32;
  localparam int ICACHE_IDX_W_DEF = 7;

  localparam logic [INST_BUS-1:0] INST_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache.
// Combinational lookup, single synchronous fill port, valid bits cleared asynchronously.
module icache_dm #(
  parameter int IDX_W  = 7,
  parameter int ADDR_W = 32,
  localparam int TAG_W = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [ADDR_W-1:0] wr_data_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [ADDR_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  // Data and tag need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_mem[wr_idx_i] <= wr_data_i;
      tag_mem[wr_idx_i]  <= wr_tag_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_mem[rd_idx_i];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: I-cache lookup on the current PC, single-outstanding
// memory refill on a miss, and the IF/ID output register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter int ADDR_W       = INST_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              branch_interception,
  input  logic              id_stall,
  output logic              if_stall,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [ADDR_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic              hit;
  logic [ADDR_W-1:0] line_data;
  logic              fill_we;
  logic              deliver;
  logic [ADDR_W-1:0] deliver_pc;
  logic [ADDR_W-1:0] deliver_inst;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^if_pc_i[1:0];

  icache_dm #(
    .IDX_W  (ICACHE_IDX_W),
    .ADDR_W (ADDR_W)
  ) u_icache (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (if_pc_i[ICACHE_IDX_W+1:2]),
    .rd_tag_i  (if_pc_i[ADDR_W-1:ICACHE_IDX_W+2]),
    .hit_o     (hit),
    .rd_data_o (line_data),
    .we_i      (fill_we),
    .wr_idx_i  (mem_addr_q[ICACHE_IDX_W+1:2]),
    .wr_tag_i  (mem_addr_q[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_data_i (mem_inst_i)
  );

  // Request FSM; fills always target mem_addr_q, even after a flush.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we      = 1'b0;
    deliver      = 1'b0;
    deliver_pc   = if_pc_i;
    deliver_inst = line_data;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          deliver = !id_stall && !branch_interception;
        end else if (!branch_interception) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {if_pc_i[ADDR_W-1:2], 2'b00};
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_valid_i) begin
          fill_we      = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = ST_IDLE;
          deliver      = !id_stall && !branch_interception;
          deliver_pc   = mem_addr_q;
          deliver_inst = mem_inst_i;
        end else if (branch_interception) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_valid_i) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // IF/ID register: flush beats stall, stall beats bubble insertion.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (branch_interception) begin
      id_valid_d = 1'b0;
    end else if (!id_stall) begin
      if (deliver) begin
        id_pc_d    = deliver_pc;
        id_inst_d  = deliver_inst;
        id_valid_d = 1'b1;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= ADDR_W'(INST_NOP);
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign if_stall = id_stall
                  || ((state_q == ST_IDLE) && !hit)
                  || ((state_q == ST_WAIT) && !mem_valid_i)
                  || (state_q == ST_DRAIN);

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory responses driven inline, deliveries to ID
// checked against a scoreboard of expected {pc, instruction} pairs.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc_i;
  logic        branch_interception;
  logic        id_stall;
  logic        if_stall;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  if_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_pc_i             (if_pc_i),
    .branch_interception (branch_interception),
    .id_stall            (id_stall),
    .if_stall            (if_stall),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_valid_i         (mem_valid_i),
    .mem_inst_i          (mem_inst_i),
    .id_pc_o             (id_pc_o),
    .id_inst_o           (id_inst_o),
    .id_valid_o          (id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing-store contents: word at 0x0 is 0x13, every address distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards compare any fresh ID delivery against the scoreboard.
  task automatic tick();
    logic hold;
    exp_t e;
    @(posedge clk);
    hold = id_stall && !branch_interception && rst_n;
    #1;
    if (id_valid_o && !hold) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, id_valid_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_inst", id_inst_o, e.inst);
        $display("deliver pc=%h inst=%h", id_pc_o, id_inst_o);
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    sb.push_back(e);
  endtask

  // Miss on pc, memory answers lat cycles after the request, delivered to ID.
  task automatic fetch_miss(input logic [31:0] pc, input int lat);
    if_pc_i = pc;
    #1 chk("miss_stall", {31'd0, if_stall}, 32'd1);
    tick();
    chk("req_up", {31'd0, mem_req_o}, 32'd1);
    chk("req_addr", mem_addr_o, {pc[31:2], 2'b00});
    for (int i = 1; i < lat; i++) begin
      chk("wait_stall", {31'd0, if_stall}, 32'd1);
      tick();
      chk("req_hold", {31'd0, mem_req_o}, 32'd1);
    end
    mem_valid_i = 1'b1;
    mem_inst_i  = mem_word(pc);
    push_exp(pc);
    #1 chk("fill_stall", {31'd0, if_stall}, 32'd0);
    tick();
    mem_valid_i = 1'b0;
    chk("req_drop", {31'd0, mem_req_o}, 32'd0);
    $display("miss serviced pc=%h lat=%0d", pc, lat);
  endtask

  task automatic hit(input logic [31:0] pc);
    if_pc_i = pc;
    push_exp(pc);
    #1 chk("hit_stall", {31'd0, if_stall}, 32'd0);
    tick();
    chk("hit_no_req", {31'd0, mem_req_o}, 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    if_pc_i             = '0;
    branch_interception = 1'b0;
    id_stall            = 1'b0;
    mem_valid_i         = 1'b0;
    mem_inst_i          = '0;

    #2;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_id_pc", id_pc_o, 32'd0);
    chk("rst_id_inst", id_inst_o, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold miss, memory answers after 3 cycles.
    fetch_miss(32'h0, 3);
    chk("cold_inst", id_inst_o, 32'h13);

    // Preload, then replay as back-to-back hits.
    fetch_miss(32'h4, 2);
    fetch_miss(32'h8, 1);
    hit(32'h0);
    hit(32'h4);
    hit(32'h8);

    // Flush while the 0x100 miss is outstanding.
    if_pc_i = 32'h100;
    #1 chk("f_miss_stall", {31'd0, if_stall}, 32'd1);
    tick();
    chk("f_req", {31'd0, mem_req_o}, 32'd1);
    tick();
    branch_interception = 1'b1;
    if_pc_i             = 32'h200;
    #1 chk("f_flush_stall", {31'd0, if_stall}, 32'd1);
    tick();
    branch_interception = 1'b0;
    chk("f_no_valid", {31'd0, id_valid_o}, 32'd0);
    chk("f_req_held", {31'd0, mem_req_o}, 32'd1);
    chk("f_addr_held", mem_addr_o, 32'h100);
    #1 chk("f_drain_stall", {31'd0, if_stall}, 32'd1);
    tick();
    mem_valid_i = 1'b1;
    mem_inst_i  = mem_word(32'h100);
    #1 chk("f_drain_fill_stall", {31'd0, if_stall}, 32'd1);
    tick();
    mem_valid_i = 1'b0;
    chk("f_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("f_drain_no_out", {31'd0, id_valid_o}, 32'd0);
    $display("flush drained pc=%h", 32'h100);
    fetch_miss(32'h200, 2);
    hit(32'h100);

    // 0x200 shares index 0 with 0x0, so 0x0 must miss again.
    fetch_miss(32'h0, 1);

    // Fill arrives while ID is stalled.
    if_pc_i = 32'h40;
    #1 tick();
    chk("s_req", {31'd0, mem_req_o}, 32'd1);
    mem_valid_i = 1'b1;
    mem_inst_i  = mem_word(32'h40);
    id_stall    = 1'b1;
    #1 chk("s_stall", {31'd0, if_stall}, 32'd1);
    tick();
    mem_valid_i = 1'b0;
    chk("s_id_pc_hold", id_pc_o, 32'h0);
    chk("s_id_inst_hold", id_inst_o, 32'h13);
    chk("s_id_valid_hold", {31'd0, id_valid_o}, 32'd0);
    chk("s_req_drop", {31'd0, mem_req_o}, 32'd0);
    id_stall = 1'b0;
    hit(32'h40);

    // Asynchronous reset while a request is outstanding.
    if_pc_i  = 32'h300;
    id_stall = 1'b1;
    tick();
    chk("r_req", {31'd0, mem_req_o}, 32'd1);
    chk("r_valid_held", {31'd0, id_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_req_clr", {31'd0, mem_req_o}, 32'd0);
    chk("r_valid_clr", {31'd0, id_valid_o}, 32'd0);
    chk("r_pc_clr", id_pc_o, 32'd0);
    #1 rst_n = 1'b1;
    id_stall = 1'b0;
    fetch_miss(32'h8, 2);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
